// File: rtl/zynq_ps7_design_wrapper.sv
// PS7-only Zynq wrapper: fixed PS pins, behavioural OCM behind a host command port,
// PL soft-reset control register and idle DDR drivers.
module zynq_ps7_design_wrapper #(
    parameter int OCM_WORDS = 1024
) (
    input  logic        FIXED_IO_ps_clk,
    input  logic        FIXED_IO_ps_porb,
    input  logic        FIXED_IO_ps_srstb,
    inout  wire  [53:0] FIXED_IO_mio,
    inout  wire         FIXED_IO_ddr_vrn,
    inout  wire         FIXED_IO_ddr_vrp,
    input  logic        host_cmd_valid,
    output logic        host_cmd_ready,
    input  logic [1:0]  host_cmd_op,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic [2:0]  host_size,
    output logic        host_rsp_valid,
    output logic [31:0] host_rsp_rdata,
    output logic        host_rsp_err,
    output logic [3:0]  FCLK_RESET_N,
    output logic [14:0] DDR_addr,
    output logic [2:0]  DDR_ba,
    output logic        DDR_ck_p,
    output logic        DDR_ck_n,
    output logic        DDR_cke,
    output logic        DDR_cs_n,
    output logic        DDR_ras_n,
    output logic        DDR_cas_n,
    output logic        DDR_we_n,
    output logic        DDR_odt,
    output logic        DDR_reset_n,
    inout  wire  [31:0] DDR_dq,
    output logic [3:0]  DDR_dm,
    inout  wire  [3:0]  DDR_dqs_p,
    inout  wire  [3:0]  DDR_dqs_n
);
    localparam int          AW        = $clog2(OCM_WORDS);
    localparam logic [31:0] OCM_BYTES = 32'(4 * OCM_WORDS);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SOFT_RST, OP_RSVD} op_t;

    logic clk;
    logic rst_raw_n;
    logic [1:0] rst_sync;
    logic rst_n;

    assign clk       = FIXED_IO_ps_clk;
    assign rst_raw_n = FIXED_IO_ps_porb & FIXED_IO_ps_srstb;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_raw_n) begin
        if (!rst_raw_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Idle DDR and PS pin drivers
    assign DDR_addr    = '0;
    assign DDR_ba      = '0;
    assign DDR_ck_p    = 1'b0;
    assign DDR_ck_n    = 1'b1;
    assign DDR_cke     = 1'b0;
    assign DDR_cs_n    = 1'b1;
    assign DDR_ras_n   = 1'b1;
    assign DDR_cas_n   = 1'b1;
    assign DDR_we_n    = 1'b1;
    assign DDR_odt     = 1'b0;
    assign DDR_reset_n = 1'b0;
    assign DDR_dm      = '0;
    assign DDR_dq      = 'z;
    assign DDR_dqs_p   = 'z;
    assign DDR_dqs_n   = 'z;
    assign FIXED_IO_mio     = 'z;
    assign FIXED_IO_ddr_vrn = 1'bz;
    assign FIXED_IO_ddr_vrp = 1'bz;

    state_t      state, state_next;
    op_t         req_op;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  fpga_rst_ctrl;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ocm [OCM_WORDS];

    logic          cmd_fire;
    logic [1:0]    lane_off;
    logic [3:0]    lane_end;
    logic          cmd_err;
    logic [AW-1:0] word_idx;
    logic [3:0]    size_be, lane_be;
    logic [31:0]   size_mask, wdata_shift, rd_data;

    assign cmd_fire = host_cmd_valid & host_cmd_ready;
    assign lane_off = req_addr[1:0];
    assign lane_end = {2'b00, lane_off} + {1'b0, req_size};
    assign word_idx = req_addr[AW+1:2];

    // Soft-reset commands ignore addr/size, so only memory ops can fail on them.
    assign cmd_err = (req_op == OP_RSVD) ||
                     ((req_op != OP_SOFT_RST) &&
                      ((req_size == 3'd0) || (req_size > 3'd4) || (lane_end > 4'd4) ||
                       (req_addr >= OCM_BYTES)));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        size_be = 4'b1111;
        case (req_size)
            3'd1:    size_be = 4'b0001;
            3'd2:    size_be = 4'b0011;
            3'd3:    size_be = 4'b0111;
            default: size_be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) size_mask[8*i +: 8] = {8{size_be[i]}};
    end

    assign lane_be     = size_be << lane_off;
    assign wdata_shift = req_wdata << {lane_off, 3'b000};
    assign rd_data     = (ocm[word_idx] >> {lane_off, 3'b000}) & size_mask;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        host_cmd_ready = (state == IDLE) && rst_n;
        host_rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op        <= OP_READ;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_size      <= '0;
            fpga_rst_ctrl <= 4'hF;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            if (cmd_fire) begin
                req_op    <= op_t'(host_cmd_op);
                req_addr  <= host_addr;
                req_wdata <= host_wdata;
                req_size  <= host_size;
            end
            if (state == EXEC) begin
                rsp_err   <= cmd_err;
                rsp_rdata <= (!cmd_err && req_op == OP_READ) ? rd_data : '0;
                if (!cmd_err && req_op == OP_SOFT_RST) fpga_rst_ctrl <= req_wdata[3:0];
            end
        end
    end

    // NOTE: the OCM array has no reset so its contents survive porb/srstb.
    always_ff @(posedge clk) begin
        if (state == EXEC && req_op == OP_WRITE && !cmd_err) begin
            for (int i = 0; i < 4; i++)
                if (lane_be[i]) ocm[word_idx][8*i +: 8] <= wdata_shift[8*i +: 8];
        end
    end

    assign host_rsp_rdata = rsp_rdata;
    assign host_rsp_err   = rsp_err;
    assign FCLK_RESET_N   = ~fpga_rst_ctrl;
endmodule

// File: tb/tb_zynq_ps7_design_wrapper.sv
// Self-checking bench for zynq_ps7_design_wrapper: directed scenarios plus random
// commands scored against a byte-array model of the OCM and soft-reset register.
module tb_zynq_ps7_design_wrapper;
    logic        clk = 1'b0;
    logic        porb, srstb;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [1:0]  host_cmd_op;
    logic [31:0] host_addr, host_wdata;
    logic [2:0]  host_size;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic        host_rsp_err;
    logic [3:0]  fclk_reset_n;
    logic [14:0] ddr_addr;
    logic [2:0]  ddr_ba;
    logic        ddr_ck_p, ddr_ck_n, ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
    logic        ddr_odt, ddr_reset_n;
    logic [3:0]  ddr_dm;
    wire  [31:0] ddr_dq;
    wire  [3:0]  ddr_dqs_p, ddr_dqs_n;
    wire  [53:0] mio;
    wire         ddr_vrn, ddr_vrp;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int last_accept = 0;

    logic [7:0] mem_m [4096];
    logic [3:0] ctrl_m;

    zynq_ps7_design_wrapper dut (
        .FIXED_IO_ps_clk(clk), .FIXED_IO_ps_porb(porb), .FIXED_IO_ps_srstb(srstb),
        .FIXED_IO_mio(mio), .FIXED_IO_ddr_vrn(ddr_vrn), .FIXED_IO_ddr_vrp(ddr_vrp),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_size(host_size), .host_rsp_valid(host_rsp_valid),
        .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
        .FCLK_RESET_N(fclk_reset_n),
        .DDR_addr(ddr_addr), .DDR_ba(ddr_ba), .DDR_ck_p(ddr_ck_p), .DDR_ck_n(ddr_ck_n),
        .DDR_cke(ddr_cke), .DDR_cs_n(ddr_cs_n), .DDR_ras_n(ddr_ras_n),
        .DDR_cas_n(ddr_cas_n), .DDR_we_n(ddr_we_n), .DDR_odt(ddr_odt),
        .DDR_reset_n(ddr_reset_n), .DDR_dq(ddr_dq), .DDR_dm(ddr_dm),
        .DDR_dqs_p(ddr_dqs_p), .DDR_dqs_n(ddr_dqs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: applies a command's rules to the byte array and control register.
    task automatic model_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] size, output logic [31:0] rdata, output logic err);
        int off = int'(addr[1:0]);
        int sz  = int'(size);
        rdata = '0;
        err = (op == 2'b11) ||
              (op != 2'b10 && (sz == 0 || sz > 4 || off + sz > 4 || addr >= 32'd4096));
        if (!err) begin
            case (op)
                2'b00: for (int i = 0; i < sz; i++)
                           rdata = rdata | (32'(mem_m[int'(addr[11:0]) + i]) << (8 * i));
                2'b01: for (int i = 0; i < sz; i++)
                           mem_m[int'(addr[11:0]) + i] = wdata[8*i +: 8];
                2'b10: ctrl_m = wdata[3:0];
                default: ;
            endcase
        end
    endtask

    // Drives one command from a negedge and checks its accept/response timing; returns at
    // the negedge after the response pulse.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output logic [31:0] rdata, output logic err,
                         output logic [3:0] fclk, output logic ok);
        int w = 0;
        ok = 1'b0; rdata = 'x; err = 1'bx; fclk = 'x;
        host_cmd_valid = 1'b1; host_cmd_op = op; host_addr = addr;
        host_wdata = wdata; host_size = size;
        while (!host_cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!host_cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: ready=%b, required 1", host_cmd_ready);
            host_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        host_cmd_valid = 1'b0;
        last_accept = cycle;
        total++;
        if (host_rsp_valid !== 1'b0 || host_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL exec_cycle: rsp_valid=%b ready=%b, required 0 0", host_rsp_valid, host_cmd_ready);
        end
        @(negedge clk);
        total++;
        if (host_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency: rsp_valid=%b, required 1", host_rsp_valid);
        end
        rdata = host_rsp_rdata; err = host_rsp_err; fclk = fclk_reset_n;
        @(negedge clk);
        total++;
        if (host_rsp_valid !== 1'b0 || host_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rsp_pulse: rsp_valid=%b ready=%b, required 0 1", host_rsp_valid, host_cmd_ready);
        end
        ok = 1'b1;
    endtask

    // Runs one command through model and DUT and compares rdata, err and FCLK_RESET_N.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rdata;
        logic        exp_err, ok;
        logic [3:0]  fclk;
        model_cmd(op, addr, wdata, size, exp_rdata, exp_err);
        issue(op, addr, wdata, size, rdata, err, fclk, ok);
        if (!ok) return;
        total++;
        if (rdata !== exp_rdata || err !== exp_err || fclk !== ~ctrl_m) begin
            bad++;
            $display("FAIL cmd op=%0d addr=%h size=%0d: rdata=%h err=%b fclk=%h, required %h %b %h",
                     op, addr, size, rdata, err, fclk, exp_rdata, exp_err, ~ctrl_m);
        end
    endtask

    task automatic test_reset();
        porb = 1'b0; srstb = 1'b0;
        host_cmd_valid = 1'b0; host_cmd_op = '0; host_addr = '0; host_wdata = '0; host_size = '0;
        ctrl_m = 4'hF;
        repeat (20) @(negedge clk);
        total++;
        if (host_cmd_ready !== 1'b0 || host_rsp_valid !== 1'b0 || host_rsp_rdata !== '0 ||
            host_rsp_err !== 1'b0 || fclk_reset_n !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: ready=%b rsp=%b rdata=%h err=%b fclk=%h, required 0 0 0 0 0",
                     host_cmd_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err, fclk_reset_n);
        end
        total++;
        if ({ddr_addr, ddr_ba, ddr_ck_p, ddr_ck_n, ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n,
             ddr_we_n, ddr_odt, ddr_reset_n, ddr_dm} !==
            {15'h0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL ddr_idle: addr=%h ba=%h ck=%b%b cke=%b cs/ras/cas/we=%b%b%b%b odt=%b rst=%b dm=%h",
                     ddr_addr, ddr_ba, ddr_ck_p, ddr_ck_n, ddr_cke, ddr_cs_n, ddr_ras_n,
                     ddr_cas_n, ddr_we_n, ddr_odt, ddr_reset_n, ddr_dm);
        end
        porb = 1'b1; srstb = 1'b1;
        @(negedge clk);
        total++;
        if (host_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_early: ready=%b one cycle after release, required 0", host_cmd_ready);
        end
        @(negedge clk);
        total++;
        if (host_cmd_ready !== 1'b1 || fclk_reset_n !== 4'h0) begin
            bad++;
            $display("FAIL ready_rise: ready=%b fclk=%h two cycles after release, required 1 0",
                     host_cmd_ready, fclk_reset_n);
        end
    endtask

    task automatic test_soft_reset();
        logic [31:0] rd; logic er;
        run_cmd(2'b10, 32'hFFFF_FFF3, 32'h1234_5671, 3'd0, rd, er);
        total++;
        if (fclk_reset_n !== 4'hE) begin
            bad++; $display("FAIL soft_reset_1: fclk=%h, required e", fclk_reset_n);
        end
        run_cmd(2'b10, 32'h0, 32'hFFFF_FFF0, 3'd7, rd, er);
        total++;
        if (fclk_reset_n !== 4'hF) begin
            bad++; $display("FAIL soft_reset_0: fclk=%h, required f", fclk_reset_n);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] rd; logic er;
        run_cmd(2'b01, 32'h0, 32'hDEAD_BEEF, 3'd4, rd, er);
        run_cmd(2'b00, 32'h0, 32'h0, 3'd4, rd, er);
        total++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            bad++; $display("FAIL round_trip: rdata=%h err=%b, required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic er;
        run_cmd(2'b01, 32'h1, 32'h0000_00AA, 3'd1, rd, er);
        run_cmd(2'b00, 32'h0, 32'h0, 3'd4, rd, er);
        total++;
        if (rd !== 32'hDEAD_AAEF) begin
            bad++; $display("FAIL partial_write: rdata=%h, required deadaaef", rd);
        end
        run_cmd(2'b00, 32'h2, 32'h0, 3'd2, rd, er);
        total++;
        if (rd !== 32'h0000_DEAD) begin
            bad++; $display("FAIL partial_read: rdata=%h, required 0000dead", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er;
        run_cmd(2'b01, 32'h1000, 32'h5555_5555, 3'd4, rd, er);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL err_range: err=%b, required 1", er); end
        run_cmd(2'b00, 32'h0, 32'h0, 3'd4, rd, er);
        total++;
        if (rd !== 32'hDEAD_AAEF) begin
            bad++; $display("FAIL err_no_write: rdata=%h, required deadaaef", rd);
        end
        run_cmd(2'b00, 32'h3, 32'h0, 3'd2, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_cross: rdata=%h err=%b, required 0 1", rd, er);
        end
        run_cmd(2'b11, 32'h0, 32'h0, 3'd4, rd, er);
        run_cmd(2'b01, 32'h4, 32'h1, 3'd0, rd, er);
        run_cmd(2'b00, 32'h4, 32'h0, 3'd5, rd, er);
        run_cmd(2'b00, 32'h0FFC, 32'h0, 3'd4, rd, er);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er;
        int first;
        run_cmd(2'b01, 32'h8, 32'hCAFE_F00D, 3'd4, rd, er);
        first = last_accept;
        run_cmd(2'b00, 32'h8, 32'h0, 3'd4, rd, er);
        total++;
        if (last_accept - first !== 3) begin
            bad++; $display("FAIL back_to_back: accept spacing=%0d, required 3", last_accept - first);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr; logic er;
        logic [1:0] op;
        int u;
        for (int w = 4; w < 64; w += 4) run_cmd(2'b01, 32'(w), 32'h0, 3'd4, rd, er);
        for (int n = 0; n < 80; n++) begin
            u  = int'($urandom_range(0, 9));
            op = (u == 0) ? 2'b11 : 2'(u % 3);
            addr = ($urandom_range(0, 7) != 0) ? 32'($urandom_range(0, 63))
                                                : 32'h1000 + 32'($urandom_range(0, 32'h0FFF_0000));
            run_cmd(op, addr, $urandom, 3'($urandom_range(0, 5)), rd, er);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd; logic er;
        int w = 0;
        bit seen = 0;
        run_cmd(2'b01, 32'h0, 32'h1357_9BDF, 3'd4, rd, er);
        run_cmd(2'b10, 32'h0, 32'h0, 3'd1, rd, er);
        host_cmd_valid = 1'b1; host_cmd_op = 2'b01; host_addr = 32'h0;
        host_wdata = 32'hFFFF_FFFF; host_size = 3'd4;
        @(posedge clk);
        @(negedge clk);
        host_cmd_valid = 1'b0;
        srstb = 1'b0;
        ctrl_m = 4'hF;
        #1;
        total++;
        if (fclk_reset_n !== 4'h0) begin
            bad++; $display("FAIL mid_reset_fclk: fclk=%h, required 0", fclk_reset_n);
        end
        repeat (5) begin @(negedge clk); if (host_rsp_valid) seen = 1; end
        srstb = 1'b1;
        while (!host_cmd_ready && w < 20) begin
            @(negedge clk); w++;
            if (host_rsp_valid) seen = 1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL mid_reset_rsp: rsp_valid seen=1, required 0"); end
        run_cmd(2'b00, 32'h0, 32'h0, 3'd4, rd, er);
        total++;
        if (rd !== 32'h1357_9BDF) begin
            bad++; $display("FAIL mid_reset_retain: rdata=%h, required 13579bdf", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
        test_reset();
        test_soft_reset();
        test_round_trip();
        test_partial();
        test_errors();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
